bkm_control_sequencer: RTL and testbench

Iteration sequencer for the BKM datapath. It accepts one operation (mode, format, initial u/v, last iteration index) and drives a combinational bkm_control_step instance once per iteration, n = 0..n_last. It feeds each step's u_np1/v_np1 back as the next u_n/v_n. Each iteration's digit pair (d_u_n, d_v_n) streams downstream over a valid/ready handshake, and the final u/v is presented with a done pulse.

---
 rtl/bkm_control_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_bkm_control_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bkm_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bkm_control_sequencer                                        |
// | Description : Iteration sequencer for the BKM datapath. Accepts one        |
// |               operation, drives an external combinational step block once  |
// |               per iteration (n = 0..n_last), feeds the step results back,  |
// |               streams each digit pair over valid/ready and presents the    |
// |               final u/v with a one-cycle done pulse.                       |
// |               Optional macro BKM_CONTROL_SEQ_STATS_EN adds a saturating    |
// |               stall counter output (stall_cnt) and a completion report.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bkm_control_sequencer #(
  parameter int W     = 64,
  parameter int LOG2N = 6
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  logic             start,
  input  logic             mode,
  input  logic [1:0]       format,
  input  logic [LOG2N-1:0] n_last,
  input  logic [W-1:0]     u_0,
  input  logic [W-1:0]     v_0,
  output logic             busy,
  output logic             step_mode,
  output logic [1:0]       step_format,
  output logic [LOG2N-1:0] step_n,
  output logic [W-1:0]     step_u_n,
  output logic [W-1:0]     step_v_n,
  input  logic [W-1:0]     step_u_np1,
  input  logic [W-1:0]     step_v_np1,
  input  logic [1:0]       step_d_u_n,
  input  logic [1:0]       step_d_v_n,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [LOG2N-1:0] dig_n,
  output logic [1:0]       dig_d_u,
  output logic [1:0]       dig_d_v,
  output logic             done,
  output logic [W-1:0]     u_fin,
  output logic [W-1:0]     v_fin
`ifdef BKM_CONTROL_SEQ_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [1:0]       format_q, format_d;
  logic [LOG2N-1:0] n_last_q, n_last_d;
  logic [LOG2N-1:0] n_q, n_d;
  logic [W-1:0]     u_q, u_d;
  logic [W-1:0]     v_q, v_d;
  logic [W-1:0]     u_fin_q, u_fin_d;
  logic [W-1:0]     v_fin_q, v_fin_d;

  // Last iteration is detected before any increment, so n_last = 2^LOG2N-1
  // finishes without step_n ever wrapping.
  logic             w_last;
  assign w_last = (n_q == n_last_q);

  // State register: reset wins over enable, enable=0 freezes the state.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= S_IDLE;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // Next-state logic; only evaluated into the register on enabled edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (dig_ready && w_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; valid and done are gated by enable so no
  // transfer or completion is signalled on a frozen cycle.
  always_comb begin
    busy      = (state_q != S_IDLE);
    dig_valid = enable && (state_q == S_RUN);
    done      = enable && (state_q == S_DONE);
  end

  // Datapath next values: latch the operation on start, advance u/v and the
  // index only on a digit transfer so the step inputs hold across stalls.
  always_comb begin
    mode_d   = mode_q;
    format_d = format_q;
    n_last_d = n_last_q;
    n_d      = n_q;
    u_d      = u_q;
    v_d      = v_q;
    u_fin_d  = u_fin_q;
    v_fin_d  = v_fin_q;
    if (state_q == S_IDLE && start) begin
      mode_d   = mode;
      format_d = format;
      n_last_d = n_last;
      n_d      = '0;
      u_d      = u_0;
      v_d      = v_0;
    end else if (state_q == S_RUN && dig_ready) begin
      u_d = step_u_np1;
      v_d = step_v_np1;
      if (w_last) begin
        u_fin_d = step_u_np1;
        v_fin_d = step_v_np1;
      end else begin
        n_d = n_q + 1'b1;
      end
    end
  end

  // Datapath registers with synchronous reset and clock enable.
  always_ff @(posedge clk) begin
    if (srst) begin
      mode_q   <= 1'b0;
      format_q <= 2'd0;
      n_last_q <= '0;
      n_q      <= '0;
      u_q      <= '0;
      v_q      <= '0;
      u_fin_q  <= '0;
      v_fin_q  <= '0;
    end else if (enable) begin
      mode_q   <= mode_d;
      format_q <= format_d;
      n_last_q <= n_last_d;
      n_q      <= n_d;
      u_q      <= u_d;
      v_q      <= v_d;
      u_fin_q  <= u_fin_d;
      v_fin_q  <= v_fin_d;
    end
  end

  assign step_mode   = mode_q;
  assign step_format = format_q;
  assign step_n      = n_q;
  assign step_u_n    = u_q;
  assign step_v_n    = v_q;
  assign dig_n       = n_q;
  assign dig_d_u     = step_d_u_n;
  assign dig_d_v     = step_d_v_n;
  assign u_fin       = u_fin_q;
  assign v_fin       = v_fin_q;

`ifdef BKM_CONTROL_SEQ_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Stall counter: cleared on an accepted start, saturates at all-ones,
  // holds after completion until the next operation.
  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = 16'd0;
    end else if (state_q == S_RUN && !dig_ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register and completion report.
  always_ff @(posedge clk) begin
    if (srst) begin
      stall_q <= 16'd0;
    end else if (enable) begin
      stall_q <= stall_d;
      if (state_q == S_DONE) begin
        $display("bkm_control_sequencer: iterations=%0d stall_cnt=%0d",
                 int'(n_last_q) + 1, stall_q);
      end
    end
  end

  assign stall_cnt = stall_q;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_bkm_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bkm_control_sequencer                                     |
// | Description : Self-checking bench for bkm_control_sequencer. Provides a    |
// |               behavioural step block, a table of directed operations,      |
// |               hand-written reset/abort sequences and randomized operations |
// |               checked against an iteration-level reference model.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bkm_control_sequencer;

  localparam int W     = 64;
  localparam int LOG2N = 6;

  logic             clk = 1'b0;
  logic             srst, enable, start, mode, dig_ready;
  logic [1:0]       format;
  logic [LOG2N-1:0] n_last;
  logic [W-1:0]     u_0, v_0;
  logic             busy, step_mode, dig_valid, done;
  logic [1:0]       step_format, step_d_u_n, step_d_v_n, dig_d_u, dig_d_v;
  logic [LOG2N-1:0] step_n, dig_n;
  logic [W-1:0]     step_u_n, step_v_n, step_u_np1, step_v_np1, u_fin, v_fin;
`ifdef BKM_CONTROL_SEQ_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bkm_control_sequencer #(.W(W), .LOG2N(LOG2N)) dut (
    .clk(clk), .srst(srst), .enable(enable), .start(start), .mode(mode),
    .format(format), .n_last(n_last), .u_0(u_0), .v_0(v_0), .busy(busy),
    .step_mode(step_mode), .step_format(step_format), .step_n(step_n),
    .step_u_n(step_u_n), .step_v_n(step_v_n), .step_u_np1(step_u_np1),
    .step_v_np1(step_v_np1), .step_d_u_n(step_d_u_n), .step_d_v_n(step_d_v_n),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_n(dig_n),
    .dig_d_u(dig_d_u), .dig_d_v(dig_d_v), .done(done), .u_fin(u_fin),
    .v_fin(v_fin)
`ifdef BKM_CONTROL_SEQ_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Behavioural stand-in for the combinational BKM step block.
  typedef struct packed {
    logic [W-1:0] u;
    logic [W-1:0] v;
    logic [1:0]   du;
    logic [1:0]   dv;
  } step_t;

  function automatic step_t step_f(input logic m, input logic [1:0] f,
                                   input logic [LOG2N-1:0] n,
                                   input logic [W-1:0] u, input logic [W-1:0] v);
    step_t s;
    s.u  = m ? (u - (v >> n)) : (u + (v >> n));
    s.v  = (m ? (v + (u >> n)) : (v - (u >> n))) ^ {62'd0, f};
    s.du = u[1:0] ^ {1'b0, m};
    s.dv = v[1:0] ^ n[1:0];
    return s;
  endfunction

  step_t env_s;
  always_comb env_s = step_f(step_mode, step_format, step_n, step_u_n, step_v_n);
  assign step_u_np1 = env_s.u;
  assign step_v_np1 = env_s.v;
  assign step_d_u_n = env_s.du;
  assign step_d_v_n = env_s.dv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    mode   = 1'($urandom);
    format = 2'($urandom);
    n_last = 6'($urandom);
    u_0    = {$urandom, $urandom};
    v_0    = {$urandom, $urandom};
  endtask

  // One operation from IDLE to back in IDLE. The model is the list of
  // per-iteration step values; the DUT must present item k until k is
  // transferred, then pulse done with the value after the last item.
  task automatic run_op(input logic m, input logic [1:0] f, input logic [5:0] nl,
                        input logic [63:0] u0, input logic [63:0] v0,
                        input int stall_k, input int stall_len,
                        input int off_k, input int off_len, input bit rnd,
                        output int done_cyc, output logic [63:0] uf,
                        output logic [63:0] vf);
    logic [63:0] eu [0:64];
    logic [63:0] ev [0:64];
    logic [1:0]  edu[0:63];
    logic [1:0]  edv[0:63];
    step_t s;
    int k, c, nli, st_left, off_left;
    bit fin;
    nli = int'(nl);
    eu[0] = u0;
    ev[0] = v0;
    for (int i = 0; i <= nli; i++) begin
      s = step_f(m, f, 6'(i), eu[i], ev[i]);
      eu[i+1] = s.u;
      ev[i+1] = s.v;
      edu[i]  = s.du;
      edv[i]  = s.dv;
    end
    uf = eu[nli+1];
    vf = ev[nli+1];
    srst = 1'b0; enable = 1'b1; start = 1'b1; mode = m; format = f;
    n_last = nl; u_0 = u0; v_0 = v0; dig_ready = 1'($urandom);
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(dig_valid), 64'd0);
    k = 0; c = 0; fin = 1'b0; done_cyc = -1;
    st_left = stall_len; off_left = off_len;
    while (!fin && c < 400) begin
      tick();
      c++;
      start = 1'($urandom);
      scramble();
      if (rnd) begin
        enable    = ($urandom_range(0, 7) != 0);
        dig_ready = ($urandom_range(0, 3) != 0);
      end else begin
        enable    = 1'b1;
        dig_ready = 1'b1;
        if (k == off_k && off_left > 0) begin
          enable = 1'b0;
          off_left--;
        end else if (k == stall_k && st_left > 0) begin
          dig_ready = 1'b0;
          st_left--;
        end
      end
      #1;
      chk("busy", 64'(busy), 64'd1);
      if (k <= nli) begin
        chk("valid", 64'(dig_valid), 64'(enable));
        chk("done_early", 64'(done), 64'd0);
        chk("dig_n", 64'(dig_n), 64'(k));
        chk("step_n", 64'(step_n), 64'(k));
        chk("step_u_n", step_u_n, eu[k]);
        chk("step_v_n", step_v_n, ev[k]);
        chk("step_mode", 64'(step_mode), 64'(m));
        chk("step_format", 64'(step_format), 64'(f));
        if (enable) begin
          chk("dig_d_u", 64'(dig_d_u), 64'(edu[k]));
          chk("dig_d_v", 64'(dig_d_v), 64'(edv[k]));
          if (dig_ready) k++;
        end
      end else begin
        chk("valid_in_done", 64'(dig_valid), 64'd0);
        chk("done", 64'(done), 64'(enable));
        if (enable) begin
          chk("u_fin", u_fin, uf);
          chk("v_fin", v_fin, vf);
          done_cyc = c;
          fin = 1'b1;
        end
      end
    end
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL op_timeout: got no done after %0d cycles, required done", c);
    end
    tick();
    start = 1'b0; enable = 1'b1;
    #1;
    chk("idle_after_busy", 64'(busy), 64'd0);
    chk("idle_after_done", 64'(done), 64'd0);
    chk("u_fin_hold", u_fin, uf);
  endtask

  typedef struct {
    logic        m;
    logic [1:0]  f;
    logic [5:0]  nl;
    logic [63:0] u0;
    logic [63:0] v0;
    int          stall_k;
    int          stall_len;
    int          off_k;
    int          off_len;
    int          exp_done;
  } vec_t;

  vec_t vec[6];

  initial begin : main
    int          dc;
    logic [63:0] uf, vf, uf_ref, vf_ref;

    vec[0] = '{1'b0, 2'd0, 6'd3,  64'd5, 64'd7, -1, 0, -1, 0, 5};
    vec[1] = '{1'b0, 2'd0, 6'd3,  64'd5, 64'd7,  1, 3, -1, 0, 8};
    vec[2] = '{1'b1, 2'd2, 6'd0,  64'h1234_5678_9abc_def0, 64'h0fed_cba9, -1, 0, -1, 0, 2};
    vec[3] = '{1'b0, 2'd1, 6'd63, 64'h8000_0000_0000_0001, 64'h5555_aaaa_5555_aaaa, -1, 0, -1, 0, 65};
    vec[4] = '{1'b1, 2'd3, 6'd5,  64'h0000_ffff_0000_ffff, 64'h1111, -1, 0, 2, 2, 9};
    vec[5] = '{1'b1, 2'd3, 6'd10, 64'hdead_beef_cafe_f00d, 64'h0123_4567_89ab_cdef, 4, 2, 7, 1, 15};

    // Reset with random inputs and start held high.
    srst = 1'b1; start = 1'b1; enable = 1'($urandom); dig_ready = 1'($urandom);
    scramble();
    repeat (2) begin
      tick();
      enable = 1'($urandom); dig_ready = 1'($urandom); scramble();
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(dig_valid), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_mode", 64'(step_mode), 64'd0);
      chk("rst_format", 64'(step_format), 64'd0);
      chk("rst_step_n", 64'(step_n), 64'd0);
      chk("rst_u_n", step_u_n, 64'd0);
      chk("rst_v_n", step_v_n, 64'd0);
      chk("rst_u_fin", u_fin, 64'd0);
      chk("rst_v_fin", v_fin, 64'd0);
    end
    srst = 1'b0; start = 1'b0; enable = 1'b1;
    repeat (3) begin
      tick();
      scramble();
      #1;
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_u_n", step_u_n, 64'd0);
    end

    // Directed operation table.
    uf_ref = '0; vf_ref = '0;
    for (int i = 0; i < 6; i++) begin
      run_op(vec[i].m, vec[i].f, vec[i].nl, vec[i].u0, vec[i].v0,
             vec[i].stall_k, vec[i].stall_len, vec[i].off_k, vec[i].off_len,
             1'b0, dc, uf, vf);
      chk($sformatf("vec%0d_done_cycle", i), 64'(dc), 64'(vec[i].exp_done));
      if (i == 0) begin
        uf_ref = uf;
        vf_ref = vf;
      end
      if (i == 1) begin
        chk("stall_same_u_fin", u_fin, uf_ref);
        chk("stall_same_v_fin", v_fin, vf_ref);
`ifdef BKM_CONTROL_SEQ_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'd3);
`endif
      end
    end

    // Start during RUN is ignored; reset mid-operation aborts without done.
    enable = 1'b1; dig_ready = 1'b1; start = 1'b1; mode = 1'b0; format = 2'd1;
    n_last = 6'd5; u_0 = 64'h100; v_0 = 64'h200;
    tick();
    start = 1'b0;
    #1;
    chk("abort_n0", 64'(dig_n), 64'd0);
    tick();
    start = 1'b1; mode = 1'b1; format = 2'd2; n_last = 6'd0; u_0 = 64'd0; v_0 = 64'd0;
    #1;
    chk("abort_n1", 64'(dig_n), 64'd1);
    tick();
    start = 1'b0;
    #1;
    chk("abort_n2", 64'(dig_n), 64'd2);
    chk("no_relatch_mode", 64'(step_mode), 64'd0);
    chk("no_relatch_format", 64'(step_format), 64'd1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(dig_valid), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_step_n", 64'(step_n), 64'd0);
    chk("abort_u_n", step_u_n, 64'd0);
    repeat (3) begin
      tick();
      #1;
      chk("abort_no_done", 64'(done), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
    end
    run_op(1'b0, 2'd2, 6'd1, 64'h77, 64'h99, -1, 0, -1, 0, 1'b0, dc, uf, vf);
    chk("after_abort_done_cycle", 64'(dc), 64'd3);

    // Randomized operations with random enable and back-pressure.
    for (int r = 0; r < 16; r++) begin
      logic [5:0] nl;
      nl = (r % 4 == 3) ? 6'd63 : 6'($urandom_range(0, 15));
      run_op(1'($urandom), 2'($urandom), nl, {$urandom, $urandom},
             {$urandom, $urandom}, -1, 0, -1, 0, 1'b1, dc, uf, vf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
